// File: rtl/pipe_ctrl_decoder.sv
// Registered, handshaked main-control decoder.
// Sequences multicycle mul/div with start/abort and branch flush.
module pipe_ctrl_decoder #(
    parameter int              OPW        = 5,
    parameter int              ALUW       = 5,
    parameter int              MD_LATENCY = 32,
    parameter logic [ALUW-1:0] MUL_CODE   = ALUW'(5'b00110),
    parameter logic [ALUW-1:0] DIV_CODE   = ALUW'(5'b00111)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  opcode,
    input  logic [ALUW-1:0] aluop_in,
    input  logic            flush,
    input  logic            md_done,
    output logic            md_start,
    output logic            md_abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ALUW-1:0] aluop,
    output logic            alu_imm,
    output logic            rwe,
    output logic            dmem_we,
    output logic            mem_to_reg,
    output logic            rd_b_sel,
    output logic            bne,
    output logic            blt,
    output logic            br,
    output logic            jp,
    output logic            jal,
    output logic            jr,
    output logic            setx,
    output logic            bex,
    output logic            md_op,
    output logic            illegal
);

    localparam int CW = $clog2(MD_LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 1);

    localparam logic [OPW-1:0] OP_R    = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_SW   = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_LW   = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_J    = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SETX = OPW'(5'b10101);
    localparam logic [OPW-1:0] OP_BEX  = OPW'(5'b10110);

    typedef struct packed {
        logic [ALUW-1:0] aluop;
        logic            alu_imm;
        logic            rwe;
        logic            dmem_we;
        logic            mem_to_reg;
        logic            rd_b_sel;
        logic            bne;
        logic            blt;
        logic            br;
        logic            jp;
        logic            jal;
        logic            jr;
        logic            setx;
        logic            bex;
        logic            md_op;
        logic            illegal;
    } ctrl_t;

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    ctrl_t          bundle;
    ctrl_t          bundle_n;
    ctrl_t          dec;
    logic           valid_n;
    logic           start_q;
    logic           start_n;
    logic           abort_q;
    logic           abort_n;
    logic           accept;
    logic           is_md;

    logic is_r;
    logic is_addi;
    logic is_sw;
    logic is_lw;
    logic is_bne;
    logic is_blt;
    logic is_j;
    logic is_jal;
    logic is_jr;
    logic is_setx;
    logic is_bex;

    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_sw   = (opcode == OP_SW);
    assign is_lw   = (opcode == OP_LW);
    assign is_bne  = (opcode == OP_BNE);
    assign is_blt  = (opcode == OP_BLT);
    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jr   = (opcode == OP_JR);
    assign is_setx = (opcode == OP_SETX);
    assign is_bex  = (opcode == OP_BEX);

    assign is_md = (aluop_in == MUL_CODE) || (aluop_in == DIV_CODE);

    // Held low while in reset so upstream never sees a phantom slot.
    assign in_ready = reset_n
                    && (state == RUN)
                    && (!out_valid || out_ready)
                    && !flush;

    assign accept = in_valid && in_ready;

    // Opcode decode; unknown opcodes raise only the illegal flag.
    always_comb begin
        dec = '0;
        unique case (1'b1)
            is_r: begin
                dec.aluop = aluop_in;
                dec.rwe   = 1'b1;
                dec.md_op = is_md;
            end
            is_addi: begin
                dec.alu_imm = 1'b1;
                dec.rwe     = 1'b1;
            end
            is_sw: begin
                dec.alu_imm  = 1'b1;
                dec.dmem_we  = 1'b1;
                dec.rd_b_sel = 1'b1;
            end
            is_lw: begin
                dec.alu_imm    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.rd_b_sel   = 1'b1;
                dec.rwe        = 1'b1;
            end
            is_bne: begin
                dec.bne   = 1'b1;
                dec.br    = 1'b1;
                dec.aluop = ALUW'(1);
            end
            is_blt: begin
                dec.blt   = 1'b1;
                dec.br    = 1'b1;
                dec.aluop = ALUW'(1);
            end
            is_j: begin
                dec.jp = 1'b1;
            end
            is_jal: begin
                dec.jal = 1'b1;
                dec.rwe = 1'b1;
            end
            is_jr: begin
                dec.jr = 1'b1;
            end
            is_setx: begin
                dec.setx = 1'b1;
                dec.rwe  = 1'b1;
            end
            is_bex: begin
                dec.bex = 1'b1;
                dec.br  = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Next-state: flush wins, then accept/handshake or md wait.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bundle_n = bundle;
        valid_n  = out_valid;
        start_n  = 1'b0;
        abort_n  = 1'b0;
        if (flush) begin
            valid_n = 1'b0;
            if (state == MD_WAIT) begin
                state_n = RUN;
                abort_n = 1'b1;
                cnt_n   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        bundle_n = dec;
                        if (dec.md_op) begin
                            valid_n = 1'b0;
                            state_n = MD_WAIT;
                            start_n = 1'b1;
                            cnt_n   = CNT_LOAD;
                        end else begin
                            valid_n = 1'b1;
                        end
                    end else if (out_ready) begin
                        valid_n = 1'b0;
                    end
                end
                MD_WAIT: begin
                    if (md_done || (cnt == '0)) begin
                        valid_n = 1'b1;
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end
    end

    // State, counter, bundle and pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            cnt       <= '0;
            bundle    <= '0;
            out_valid <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bundle    <= bundle_n;
            out_valid <= valid_n;
            start_q   <= start_n;
            abort_q   <= abort_n;
        end
    end

    // A flush in the launch cycle cancels the start pulse.
    assign md_start = start_q && !flush;
    assign md_abort = abort_q;

    assign aluop      = bundle.aluop;
    assign alu_imm    = bundle.alu_imm;
    assign rwe        = bundle.rwe;
    assign dmem_we    = bundle.dmem_we;
    assign mem_to_reg = bundle.mem_to_reg;
    assign rd_b_sel   = bundle.rd_b_sel;
    assign bne        = bundle.bne;
    assign blt        = bundle.blt;
    assign br         = bundle.br;
    assign jp         = bundle.jp;
    assign jal        = bundle.jal;
    assign jr         = bundle.jr;
    assign setx       = bundle.setx;
    assign bex        = bundle.bex;
    assign md_op      = bundle.md_op;
    assign illegal    = bundle.illegal;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Directed bench for pipe_ctrl_decoder.
// Uses MD_LATENCY=4 so the timeout path is short.
module tb_pipe_ctrl_decoder;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] opcode;
    logic [4:0] aluop_in;
    logic       flush;
    logic       md_done;
    logic       md_start;
    logic       md_abort;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] aluop;
    logic       alu_imm;
    logic       rwe;
    logic       dmem_we;
    logic       mem_to_reg;
    logic       rd_b_sel;
    logic       bne;
    logic       blt;
    logic       br;
    logic       jp;
    logic       jal;
    logic       jr;
    logic       setx;
    logic       bex;
    logic       md_op;
    logic       illegal;

    int passed = 0;
    int total  = 0;

    pipe_ctrl_decoder #(
        .OPW(5),
        .ALUW(5),
        .MD_LATENCY(4),
        .MUL_CODE(5'b00110),
        .DIV_CODE(5'b00111)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opcode(opcode),
        .aluop_in(aluop_in),
        .flush(flush),
        .md_done(md_done),
        .md_start(md_start),
        .md_abort(md_abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .aluop(aluop),
        .alu_imm(alu_imm),
        .rwe(rwe),
        .dmem_we(dmem_we),
        .mem_to_reg(mem_to_reg),
        .rd_b_sel(rd_b_sel),
        .bne(bne),
        .blt(blt),
        .br(br),
        .jp(jp),
        .jal(jal),
        .jr(jr),
        .setx(setx),
        .bex(bex),
        .md_op(md_op),
        .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs,
                        input logic [4:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        opcode    = 5'b01000;
        aluop_in  = 5'b00000;
        flush     = 1'b0;
        md_done   = 1'b0;
        out_ready = 1'b1;

        // reset held three cycles with a valid lw on the inputs
        repeat (3) tick();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_rwe", rwe, 1'b0);
        chk1("rst_mem_to_reg", mem_to_reg, 1'b0);
        chk1("rst_md_start", md_start, 1'b0);
        chk1("rst_md_abort", md_abort, 1'b0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        chk1("post_rst_in_ready", in_ready, 1'b1);

        // lw then addi back-to-back
        in_valid = 1'b1;
        opcode   = 5'b01000;
        tick();
        chk1("lw_valid", out_valid, 1'b1);
        chk1("lw_mem_to_reg", mem_to_reg, 1'b1);
        chk1("lw_alu_imm", alu_imm, 1'b1);
        chk1("lw_rd_b_sel", rd_b_sel, 1'b1);
        chk1("lw_rwe", rwe, 1'b1);
        opcode = 5'b00101;
        tick();
        chk1("addi_valid", out_valid, 1'b1);
        chk1("addi_alu_imm", alu_imm, 1'b1);
        chk1("addi_rwe", rwe, 1'b1);
        chk1("addi_mem_to_reg", mem_to_reg, 1'b0);
        chk1("addi_rd_b_sel", rd_b_sel, 1'b0);
        in_valid = 1'b0;
        tick();
        chk1("drain_valid", out_valid, 1'b0);

        // sw with execute stalled four cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        opcode    = 5'b00111;
        tick();
        opcode = 5'b00101;
        #1;
        chk1("sw_valid", out_valid, 1'b1);
        chk1("sw_dmem_we", dmem_we, 1'b1);
        chk1("sw_rd_b_sel", rd_b_sel, 1'b1);
        chk1("sw_stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("sw_hold_valid", out_valid, 1'b1);
            chk1("sw_hold_dmem_we", dmem_we, 1'b1);
            chk1("sw_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk1("sw_release_in_ready", in_ready, 1'b1);
        tick();
        chk1("after_sw_valid", out_valid, 1'b1);
        chk1("after_sw_dmem_we", dmem_we, 1'b0);
        chk1("after_sw_alu_imm", alu_imm, 1'b1);
        chk1("after_sw_rwe", rwe, 1'b1);
        in_valid = 1'b0;
        tick();
        chk1("after_sw_drain", out_valid, 1'b0);

        // MUL completed early by md_done
        in_valid = 1'b1;
        opcode   = 5'b00000;
        aluop_in = 5'b00110;
        tick();
        in_valid = 1'b0;
        #1;
        chk1("mul_start", md_start, 1'b1);
        chk1("mul_wait_valid", out_valid, 1'b0);
        chk1("mul_wait_in_ready", in_ready, 1'b0);
        tick();
        chk1("mul_start_once", md_start, 1'b0);
        chk1("mul_wait_in_ready2", in_ready, 1'b0);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        #1;
        chk1("mul_done_valid", out_valid, 1'b1);
        chk1("mul_md_op", md_op, 1'b1);
        chk5("mul_aluop", aluop, 5'b00110);
        chk1("mul_rwe", rwe, 1'b1);
        chk1("mul_no_restart", md_start, 1'b0);
        tick();
        chk1("mul_drain", out_valid, 1'b0);

        // DIV with no md_done: bundle 4 cycles after md_start
        in_valid = 1'b1;
        aluop_in = 5'b00111;
        tick();
        in_valid = 1'b0;
        #1;
        chk1("div_start", md_start, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("div_wait_valid", out_valid, 1'b0);
            chk1("div_wait_start", md_start, 1'b0);
        end
        tick();
        chk1("div_timeout_valid", out_valid, 1'b1);
        chk1("div_md_op", md_op, 1'b1);
        chk5("div_aluop", aluop, 5'b00111);
        tick();
        chk1("div_drain", out_valid, 1'b0);

        // md_done coinciding with the last timeout cycle completes once
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk1("div2_wait_valid", out_valid, 1'b0);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        #1;
        chk1("div2_done_valid", out_valid, 1'b1);
        tick();
        chk1("div2_once_valid", out_valid, 1'b0);
        chk1("div2_in_ready", in_ready, 1'b1);

        // flush mid-wait aborts the divide
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        chk1("flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk1("flush_abort", md_abort, 1'b1);
        chk1("flush_valid", out_valid, 1'b0);
        chk1("flush_in_ready_next", in_ready, 1'b1);
        tick();
        chk1("flush_abort_once", md_abort, 1'b0);
        repeat (3) tick();
        chk1("flush_no_late_valid", out_valid, 1'b0);

        // flush in the launch cycle suppresses md_start
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk1("flush_start_suppr", md_start, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk1("flush_start_abort", md_abort, 1'b1);
        tick();
        chk1("flush_start_abort_end", md_abort, 1'b0);
        chk1("flush_start_valid", out_valid, 1'b0);

        // flush alongside in_valid blocks the accept
        in_valid = 1'b1;
        opcode   = 5'b00101;
        flush    = 1'b1;
        #1;
        chk1("flush_iv_in_ready", in_ready, 1'b0);
        tick();
        chk1("flush_iv_valid", out_valid, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();

        // illegal, setx, bex, bne
        in_valid = 1'b1;
        opcode   = 5'b11111;
        tick();
        chk1("ill_valid", out_valid, 1'b1);
        chk1("ill_flag", illegal, 1'b1);
        chk1("ill_rwe", rwe, 1'b0);
        chk1("ill_dmem_we", dmem_we, 1'b0);
        chk5("ill_aluop", aluop, 5'b00000);
        opcode = 5'b10101;
        tick();
        chk1("setx_flag", setx, 1'b1);
        chk1("setx_rwe", rwe, 1'b1);
        chk1("setx_ill", illegal, 1'b0);
        opcode = 5'b10110;
        tick();
        chk1("bex_flag", bex, 1'b1);
        chk1("bex_br", br, 1'b1);
        chk1("bex_rwe", rwe, 1'b0);
        opcode = 5'b00010;
        tick();
        chk1("bne_flag", bne, 1'b1);
        chk1("bne_br", br, 1'b1);
        chk5("bne_aluop", aluop, 5'b00001);
        opcode = 5'b00011;
        tick();
        chk1("jal_flag", jal, 1'b1);
        chk1("jal_rwe", rwe, 1'b1);
        in_valid = 1'b0;
        tick();
        chk1("dec_drain", out_valid, 1'b0);

        // async reset in the middle of a divide wait
        in_valid = 1'b1;
        opcode   = 5'b00000;
        aluop_in = 5'b00111;
        tick();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk1("arst_md_start", md_start, 1'b0);
        chk1("arst_md_op", md_op, 1'b0);
        chk1("arst_in_ready", in_ready, 1'b0);
        tick();
        chk1("arst_no_abort", md_abort, 1'b0);
        reset_n = 1'b1;
        repeat (5) begin
            tick();
            chk1("arst_after_abort", md_abort, 1'b0);
            chk1("arst_after_valid", out_valid, 1'b0);
        end
        chk1("arst_after_in_ready", in_ready, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
